sort_packet_tx: RTL and testbench

- Single-clock packet transmitter: a local loader fills an internal buffer with one packet, and the block then streams it out as a valid/sop/eop/data packet under src_ready backpressure.
- Drives the sink side of the packet sorter and serves as its stimulus source in system tests.
- One packet in flight at a time. Loading and sending alternate, with no overlap.

---
 rtl/sort_packet_tx.sv | 171 +++++++++++++++++
 tb/tb_sort_packet_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort_packet_tx.sv
// sort_packet_tx: single-packet buffer filled by a local loader,
// then streamed out as a valid/sop/eop beat sequence.
module sort_packet_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LENGTH = 8
) (
  input  logic                  src_clock,
  input  logic                  src_reset_n,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  src_ready,
  output logic                  src_valid,
  output logic                  src_sop,
  output logic                  src_eop,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic                  pkt_done,
  output logic                  pkt_trunc
);

  localparam int CW = $clog2(MAX_LENGTH) + 1;
  localparam int IW = $clog2(MAX_LENGTH);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         len_q, len_d;
  logic                  ld_ready_q, ld_ready_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  trunc_q, trunc_d;

  logic [DATA_WIDTH-1:0] mem_q [MAX_LENGTH];
  logic                  wr_en;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic                  ld_acc;
  logic                  src_acc;

  assign ld_acc  = ld_valid && ld_ready_q;
  assign src_acc = valid_q && src_ready;
  assign wr_idx  = wr_cnt_q[IW-1:0];
  assign rd_idx  = IW'(rd_cnt_q + CW'(1));

  // Next-state logic for the load / drain / send sequence
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    len_d      = len_q;
    ld_ready_d = ld_ready_q;
    valid_d    = valid_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    data_d     = data_q;
    done_d     = 1'b0;
    trunc_d    = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        ld_ready_d = 1'b1;
        if (ld_acc) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (ld_last) begin
            len_d      = wr_cnt_q + CW'(1);
            state_d    = S_SEND;
            ld_ready_d = 1'b0;
            valid_d    = 1'b1;
            sop_d      = 1'b1;
            eop_d      = (wr_cnt_q == '0);
            // word 0 is being written this same edge
            data_d     = (wr_cnt_q == '0) ? ld_data : mem_q[0];
          end else if (wr_cnt_q == CW'(MAX_LENGTH - 1)) begin
            len_d   = CW'(MAX_LENGTH);
            trunc_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        ld_ready_d = 1'b1;
        if (ld_acc && ld_last) begin
          state_d    = S_SEND;
          ld_ready_d = 1'b0;
          valid_d    = 1'b1;
          sop_d      = 1'b1;
          eop_d      = 1'b0;
          data_d     = mem_q[0];
        end
      end
      S_SEND: begin
        ld_ready_d = 1'b0;
        if (src_acc) begin
          if (eop_q) begin
            valid_d    = 1'b0;
            sop_d      = 1'b0;
            eop_d      = 1'b0;
            data_d     = '0;
            done_d     = 1'b1;
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            ld_ready_d = 1'b1;
            state_d    = S_LOAD;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            data_d   = mem_q[rd_idx];
            sop_d    = 1'b0;
            eop_d    = ((rd_cnt_q + CW'(2)) == len_q);
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge src_clock or negedge src_reset_n) begin
    if (!src_reset_n) begin
      state_q    <= S_LOAD;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      len_q      <= '0;
      ld_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      len_q      <= len_d;
      ld_ready_q <= ld_ready_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      data_q     <= data_d;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
    end
  end

  // Packet buffer; contents need no reset
  always_ff @(posedge src_clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= ld_data;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign src_valid = valid_q;
  assign src_sop   = sop_q;
  assign src_eop   = eop_q;
  assign src_data  = data_q;
  assign pkt_done  = done_q;
  assign pkt_trunc = trunc_q;

endmodule

// File: tb/tb_sort_packet_tx.sv
// tb_sort_packet_tx: directed and random packets checked against
// a queue-based model of the expected beat stream.
module tb_sort_packet_tx;

  localparam int DW  = 8;
  localparam int MAX = 8;

  typedef logic [DW-1:0] q8_t[$];

  logic          clk;
  logic          rst_n;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          src_ready;
  logic          src_valid;
  logic          src_sop;
  logic          src_eop;
  logic [DW-1:0] src_data;
  logic          pkt_done;
  logic          pkt_trunc;

  int checks   = 0;
  int failures = 0;

  sort_packet_tx #(
    .DATA_WIDTH(DW),
    .MAX_LENGTH(MAX)
  ) dut (
    .src_clock  (clk),
    .src_reset_n(rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .src_ready  (src_ready),
    .src_valid  (src_valid),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_data   (src_data),
    .pkt_done   (pkt_done),
    .pkt_trunc  (pkt_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=progress", tag);
  endtask

  // mode 0: always ready, 1: random ready, 2: 3-cycle stall on beat 1.
  // gap 1: random loader bubbles. hold: keep ld_valid high with the
  // next packet's first word while this one is sent.
  task automatic run_pkt(input q8_t w, input int mode, input int gap,
                         input bit hold, input logic [DW-1:0] hd,
                         input bit hl, output int span);
    q8_t exp_q;
    int  n;
    int  nexp;
    int  i;
    int  k;
    int  cyc;
    int  stall;
    bit  acc;
    bit  rdy;
    n    = w.size();
    nexp = (n > MAX) ? MAX : n;
    for (int j = 0; j < nexp; j++) exp_q.push_back(w[j]);
    i   = 0;
    cyc = 0;
    while (i < n) begin
      ld_valid  = (gap == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      ld_data   = w[i];
      ld_last   = ld_valid ? (i == n - 1) : 1'($urandom_range(0, 1));
      src_ready = 1'($urandom_range(0, 1));
      acc       = ld_valid && ld_ready;
      @(negedge clk);
      cyc++;
      chk("idle_valid", src_valid, (acc && i == n - 1));
      if (acc) begin
        chk("trunc", pkt_trunc, (i == MAX - 1 && n > MAX));
        chk("ld_ready_load", ld_ready, (i != n - 1));
        i++;
      end else begin
        chk("trunc_idle", pkt_trunc, 0);
      end
      if (cyc > 500) begin
        timeout("load_timeout");
        break;
      end
    end
    ld_valid = hold;
    ld_data  = hd;
    ld_last  = hl;
    k     = 0;
    span  = 0;
    stall = 0;
    while (k < nexp && span < 200) begin
      chk("valid", src_valid, 1);
      chk("ld_ready_send", ld_ready, 0);
      chk("data", src_data, exp_q[k]);
      chk("sop", src_sop, (k == 0));
      chk("eop", src_eop, (k == nexp - 1));
      chk("done_low", pkt_done, 0);
      if (mode == 0) begin
        rdy = 1'b1;
      end else if (mode == 1) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = !(k == 1 && stall < 3);
        if (!rdy) stall++;
      end
      src_ready = rdy;
      @(negedge clk);
      span++;
      if (rdy) k++;
    end
    if (k < nexp) begin
      timeout("send_timeout");
    end else begin
      chk("end_valid", src_valid, 0);
      chk("end_sop", src_sop, 0);
      chk("end_eop", src_eop, 0);
      chk("end_data", src_data, 0);
      chk("pkt_done", pkt_done, 1);
      chk("ld_ready_back", ld_ready, 1);
    end
  endtask

  initial begin
    q8_t pk;
    int  span;
    int  len;
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    src_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_valid", src_valid, 0);
    chk("rst_sop", src_sop, 0);
    chk("rst_eop", src_eop, 0);
    chk("rst_data", src_data, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_trunc", pkt_trunc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ld_ready", ld_ready, 1);

    // basic 3-word packet, no backpressure
    pk.delete();
    pk.push_back(8'h05); pk.push_back(8'h02); pk.push_back(8'h09);
    run_pkt(pk, 0, 0, 1'b0, 8'h00, 1'b0, span);
    chk("span_basic", span, 3);

    // same packet, stalled three cycles on the middle beat
    run_pkt(pk, 2, 0, 1'b0, 8'h00, 1'b0, span);
    chk("span_stall", span, 6);

    // single-word packet
    pk.delete();
    pk.push_back(8'h7F);
    run_pkt(pk, 0, 0, 1'b0, 8'h00, 1'b0, span);
    chk("span_single", span, 1);

    // oversized packet truncated to MAX words
    pk.delete();
    for (int j = 0; j < 10; j++) pk.push_back(8'(8'h10 + j));
    run_pkt(pk, 0, 0, 1'b0, 8'h00, 1'b0, span);
    chk("span_trunc", span, MAX);

    // reset during the second beat of a 4-word packet
    for (int j = 0; j < 4; j++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(8'h40 + j);
      ld_last  = (j == 3);
      @(negedge clk);
    end
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    src_ready = 1'b1;
    chk("rst_pk_b0", src_data, 8'h40);
    @(negedge clk);
    chk("rst_pk_b1", src_data, 8'h41);
    src_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", src_valid, 0);
    chk("async_sop", src_sop, 0);
    chk("async_eop", src_eop, 0);
    chk("async_data", src_data, 0);
    chk("async_ld_ready", ld_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ld_ready", ld_ready, 1);
    chk("post_rst_valid", src_valid, 0);
    pk.delete();
    pk.push_back(8'hA1); pk.push_back(8'hA2);
    run_pkt(pk, 0, 0, 1'b0, 8'h00, 1'b0, span);

    // back-to-back with ld_valid held high across packets
    pk.delete();
    pk.push_back(8'h01); pk.push_back(8'h02);
    run_pkt(pk, 0, 0, 1'b1, 8'h03, 1'b1, span);
    pk.delete();
    pk.push_back(8'h03);
    run_pkt(pk, 0, 0, 1'b0, 8'h00, 1'b0, span);

    // random packets, bubbles and backpressure
    for (int p = 0; p < 12; p++) begin
      pk.delete();
      len = $urandom_range(1, MAX + 3);
      for (int j = 0; j < len; j++) pk.push_back(8'($urandom));
      run_pkt(pk, 1, 1, 1'b0, 8'h00, 1'b0, span);
      ld_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
